bcd_chain_ctrl: RTL and testbench

Controller that sequences a cascade of DIGITS BCD digit counters as one multi-digit decimal counter.
- Divides clk by PRESCALE to form count ticks and generates per-digit ripple-carry enables.
- Runs a start/stop/clear command FSM and compares the count against a programmed target.
- Stops and pulses done when the target is reached.
- Sits above the single-digit BCD counter and turns it into a programmable decimal timer/event counter.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_chain_ctrl.sv | 135 +++++++++++++
 tb/tb_bcd_chain_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the BCD counter chain.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counter: steps 0..9 when enabled, flags its carry when it rolls over.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry_out
);

  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] q_q;

  // Any value at or above 9 rolls to 0 so the digit always lands back in BCD range.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q >= BCD_MAX) ? '0 : q_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = en & (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Multi-digit decimal counter controller: prescaled ticks, ripple-carry enables,
// start/stop/clear FSM and target comparator.
module bcd_chain_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic [BCD_W*DIGITS-1:0]   target,
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic [DIGITS-1:0]         digit_en,
  output logic                      running,
  output logic                      done
);

  localparam int unsigned CNT_W = BCD_W * DIGITS;
  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  ctrl_state_e      state_d, state_q;
  logic [PS_W-1:0]  presc_d, presc_q;
  logic             running_d, running_q;
  logic             done_d, done_q;

  logic             presc_last_c;
  logic             tick_c;
  logic             digit_clr_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  assign presc_last_c = (presc_q == PS_W'(PRESCALE - 1));
  // stop and clear both suppress the tick, so a coincident stop never increments.
  assign tick_c = (state_q == ST_RUN) & presc_last_c & ~stop & ~clear;

  // Each digit is enabled by the carry of the digit below; cnt_nxt_c is the
  // value the chain will hold after this edge, used by the comparator.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic             en_w;
    logic             carry_w;
    logic [BCD_W-1:0] q_w;

    if (i == 0) begin : g_lsd
      assign en_w = tick_c;
    end else begin : g_upper
      assign en_w = g_dig[i-1].carry_w;
    end

    bcd_digit u_digit (
      .clk       (clk),
      .reset     (reset),
      .clr       (digit_clr_c),
      .en        (en_w),
      .q         (q_w),
      .carry_out (carry_w)
    );

    assign count[i*BCD_W +: BCD_W]     = q_w;
    assign digit_en[i]                 = en_w;
    assign cnt_nxt_c[i*BCD_W +: BCD_W] = carry_w ? '0 : (en_w ? q_w + BCD_W'(1) : q_w);
  end

  // Command FSM and prescaler; priority is clear > stop > start.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    done_d      = 1'b0;
    digit_clr_c = 1'b0;

    if (clear) begin
      state_d     = ST_IDLE;
      presc_d     = '0;
      digit_clr_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!stop && start) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_HOLD;
          end else if (presc_last_c) begin
            presc_d = '0;
            if (cnt_nxt_c == target) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PS_W'(1);
          end
        end
        ST_HOLD: begin
          if (!stop && start) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (!stop && start) begin
            state_d     = ST_RUN;
            presc_d     = '0;
            digit_clr_c = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Bench for bcd_chain_ctrl: decimal-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bcd_chain_ctrl;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 2;
  localparam int W        = 4 * DIGITS;
  localparam int MODV     = 100;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              clear = 1'b0;
  logic [W-1:0]      target = '0;
  logic [W-1:0]      count;
  logic [DIGITS-1:0] digit_en;
  logic              running;
  logic              done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_state = S_IDLE;
  int m_cnt   = 0;
  int m_ph    = 0;
  bit m_done  = 1'b0;

  bcd_chain_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .target   (target),
    .count    (count),
    .digit_en (digit_en),
    .running  (running),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal value of the target, or -1 when any nibble is not a BCD digit.
  function automatic int tgt_dec(input logic [W-1:0] t);
    int v = 0;
    int m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[4*i +: 4] > 4'd9) return -1;
      v = v + int'(t[4*i +: 4]) * m;
      m = m * 10;
    end
    return v;
  endfunction

  function automatic bit model_tick();
    return (m_state == S_RUN) && (m_ph == PRESCALE - 1) && !stop && !clear;
  endfunction

  // Digit i moves on a tick when every lower decimal digit is 9.
  function automatic logic [DIGITS-1:0] exp_en();
    logic [DIGITS-1:0] e = '0;
    int v = m_cnt;
    if (!model_tick()) return e;
    e[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      if (v % 10 != 9) break;
      e[i] = 1'b1;
      v = v / 10;
    end
    return e;
  endfunction

  always @(posedge clk) begin : model_blk
    int nc;
    int ns;
    int np;
    bit nd;
    bit tk;
    nc = m_cnt;
    ns = m_state;
    np = m_ph;
    nd = 1'b0;
    tk = model_tick();
    if (!reset) begin
      nc = 0; ns = S_IDLE; np = 0;
    end else if (clear) begin
      nc = 0; ns = S_IDLE; np = 0;
    end else if (stop) begin
      if (ns == S_RUN) ns = S_HOLD;
    end else if (ns == S_RUN) begin
      if (tk) begin
        nc = (nc + 1) % MODV;
        np = 0;
        if (nc == tgt_dec(target)) begin
          ns = S_DONE;
          nd = 1'b1;
        end
      end else begin
        np = np + 1;
      end
    end else if (start) begin
      if (ns == S_IDLE) begin ns = S_RUN; np = 0; end
      else if (ns == S_HOLD) ns = S_RUN;
      else if (ns == S_DONE) begin ns = S_RUN; np = 0; nc = 0; end
    end
    m_cnt   <= nc;
    m_state <= ns;
    m_ph    <= np;
    m_done  <= nd;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(to_bcd(m_cnt)));
      check("running", 32'(running), 32'(m_state == S_RUN));
      check("done", 32'(done), 32'(m_done));
      check("digit_en", 32'(digit_en), 32'(exp_en()));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    edge1();
    start = 1'b0;
  endtask

  // Returns the number of edges until done is seen (-1 on timeout) and how
  // many of those edges had both digits enabled.
  task automatic run_until_done(input int max_edges, output int edges, output int n11);
    edges = -1;
    n11 = 0;
    for (int i = 1; i <= max_edges; i++) begin
      @(negedge clk);
      if (digit_en == 2'b11) n11++;
      edge1();
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin : main
    int edges;
    int n11;
    int wraps;
    int dseen;
    logic [W-1:0] prev;

    // 1: reset dominates a held start
    reset = 1'b0; start = 1'b1;
    edge1();
    chk_en = 1'b1;
    edge1();
    check("rst_count", 32'(count), 32'h00);
    check("rst_running", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_digit_en", 32'(digit_en), 32'h0);
    reset = 1'b1; start = 1'b0;
    repeat (3) edge1();
    check("idle_count", 32'(count), 32'h00);

    // 2: count to 15
    target = 8'h15;
    pulse_start();
    run_until_done(100, edges, n11);
    check("t15_latency", 32'(edges), 32'd30);
    check("t15_en11", 32'(n11), 32'd1);
    check("t15_count", 32'(count), 32'h15);
    check("t15_running", 32'(running), 32'h0);
    repeat (10) edge1();
    check("t15_hold", 32'(count), 32'h15);
    check("t15_done_low", 32'(done), 32'h0);

    // 3: target 0 needs a full wrap
    target = 8'h00;
    pulse_start();
    run_until_done(250, edges, n11);
    check("t00_latency", 32'(edges), 32'd200);
    check("t00_en11", 32'(n11), 32'd10);
    check("t00_count", 32'(count), 32'h00);

    // 4: stop mid-prescale, resume keeps phase
    target = 8'h20;
    pulse_start();
    repeat (9) edge1();
    check("t20_pre_stop", 32'(count), 32'h04);
    stop = 1'b1;
    repeat (5) edge1();
    check("t20_hold_count", 32'(count), 32'h04);
    check("t20_hold_running", 32'(running), 32'h0);
    stop = 1'b0;
    pulse_start();
    check("t20_resume_running", 32'(running), 32'h1);
    check("t20_resume_count", 32'(count), 32'h04);
    edge1();
    check("t20_first_inc", 32'(count), 32'h05);
    run_until_done(100, edges, n11);
    check("t20_latency", 32'(edges), 32'd30);
    check("t20_count", 32'(count), 32'h20);

    // 5: clear wins over stop and start; reset mid-run
    target = 8'h50;
    pulse_start();
    repeat (14) edge1();
    check("t5_count07", 32'(count), 32'h07);
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    edge1();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    check("t5_clr_count", 32'(count), 32'h00);
    check("t5_clr_running", 32'(running), 32'h0);
    repeat (3) edge1();
    check("t5_idle_count", 32'(count), 32'h00);
    pulse_start();
    repeat (66) edge1();
    check("t5_count33", 32'(count), 32'h33);
    reset = 1'b0;
    edge1();
    reset = 1'b1;
    check("t5_rst_count", 32'(count), 32'h00);
    check("t5_rst_running", 32'(running), 32'h0);
    check("t5_rst_done", 32'(done), 32'h0);
    check("t5_rst_digit_en", 32'(digit_en), 32'h0);

    // 6: non-BCD target never matches
    target = 8'h1A;
    pulse_start();
    wraps = 0;
    dseen = 0;
    prev = count;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (done) dseen++;
      if (prev == 8'h99 && count == 8'h00) wraps++;
      prev = count;
      edge1();
    end
    check("t1a_wraps", 32'(wraps), 32'd2);
    check("t1a_no_done", 32'(dseen), 32'd0);
    check("t1a_running", 32'(running), 32'h1);
    check("t1a_count", 32'(count), 32'h10);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
